// File: rtl/switch_pkg.sv
// Shared types and helpers for the switch sequence decoder: FSM state encoding,
// Johnson-code position lookup and the illegal-pattern field value.
package switch_pkg;

    typedef logic [0:0] seq_state_t;
    localparam seq_state_t ST_TRACK = 1'b0;
    localparam seq_state_t ST_FAULT = 1'b1;

    function automatic int sw_err_val(input int n);
        return n + 1;
    endfunction

    // Returns the Johnson position (0..2n-1) of a code, or -1 for an illegal pattern.
    function automatic int johnson_pos(input logic [7:0] code, input int n);
        int         res;
        logic [7:0] exp_code;
        res = -1;
        for (int k = 0; k < 16; k++) begin
            if (k < 2 * n) begin
                exp_code = '0;
                for (int i = 0; i < 8; i++) begin
                    if (i < n)
                        exp_code[i] = (k <= n) ? (i >= n - k) : (i < 2 * n - k);
                end
                if (code == exp_code && res < 0)
                    res = k;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Single-channel 2-flop synchroniser followed by a stable-count debouncer.
module sw_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sw,
    output logic o_stable
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          r_s1, r_s2, r_stable;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_s1 <= i_sw;
            r_s2 <= r_s1;
            // The accepting cycle is the DEB_CYCLES-th consecutive mismatch.
            if (r_s2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/switch_seq_decoder.sv
// Debounced switch bank -> per-switch numeric fields, with optional Johnson
// sequence checker enabled by SWITCH_SEQ_CHECK_EN.
module switch_seq_decoder
    import switch_pkg::*;
#(
    parameter int N          = 3,
    parameter int DEB_CYCLES = 4,
    parameter int W          = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N-1:0]              sw,
    output logic [N*W-1:0]            nums,
    output logic                      code_valid,
    output logic                      chg,
    output logic [$clog2(2*N)-1:0]    pos,
    output logic                      dir,
    output logic                      seq_err
);
    localparam int PW  = $clog2(2 * N);
    localparam int ERR = sw_err_val(N);

    logic [N-1:0]   w_stable;
    logic [N-1:0]   r_prev;
    logic [7:0]     w_code8;
    int             w_jpos;
    logic           w_legal;
    logic           w_changed;
    logic [N*W-1:0] r_nums;
    logic           r_valid;
    logic           r_chg;

    for (genvar g = 0; g < N; g++) begin : g_deb
        sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .i_clk    (clk),
            .i_rst_n  (rst_n),
            .i_sw     (sw[g]),
            .o_stable (w_stable[g])
        );
    end

    always_comb begin
        w_code8        = '0;
        w_code8[N-1:0] = w_stable;
        w_jpos         = johnson_pos(w_code8, N);
        w_legal        = (w_jpos >= 0);
        w_changed      = (w_stable != r_prev);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev  <= '0;
            r_nums  <= '0;
            r_valid <= 1'b1;
            r_chg   <= 1'b0;
        end else begin
            r_prev <= w_stable;
            r_chg  <= w_changed;
            if (w_changed) begin
                r_valid <= w_legal;
                for (int i = 0; i < N; i++)
                    r_nums[i*W +: W] <= !w_legal   ? W'(ERR) :
                                        w_stable[i] ? W'(i + 1) : '0;
            end
        end
    end

    assign nums       = r_nums;
    assign code_valid = r_valid;
    assign chg        = r_chg;

`ifdef SWITCH_SEQ_CHECK_EN
    seq_state_t    r_state;
    logic [PW-1:0] r_pos;
    logic          r_dir;
    logic [PW-1:0] w_new, w_fwd, w_bwd;

    always_comb begin
        w_new = PW'(w_jpos);
        w_fwd = PW'((int'(r_pos) + 1) % (2 * N));
        w_bwd = PW'((int'(r_pos) + 2 * N - 1) % (2 * N));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_TRACK;
            r_pos   <= '0;
            r_dir   <= 1'b1;
        end else if (w_changed) begin
            case (r_state)
                ST_TRACK: begin
                    if (w_legal && w_new == w_fwd) begin
                        r_pos <= w_new;
                        r_dir <= 1'b1;
                    end else if (w_legal && w_new == w_bwd) begin
                        r_pos <= w_new;
                        r_dir <= 1'b0;
                    end else begin
                        r_state <= ST_FAULT;
                    end
                end
                default: begin
                    if (w_stable == '0) begin
                        r_state <= ST_TRACK;
                        r_pos   <= '0;
                    end
                end
            endcase
        end
    end

    assign pos     = r_pos;
    assign dir     = r_dir;
    assign seq_err = (r_state == ST_FAULT);
`else
    assign pos     = '0;
    assign dir     = 1'b1;
    assign seq_err = 1'b0;
`endif

endmodule

// File: doc/switch_seq_decoder.md
# switch_seq_decoder

Parametrised successor to the board's switch-to-number decoder. Synchronises and debounces N slide switches, then maps each registered pattern to per-switch numeric fields with an error code for illegal patterns. With the sequence checker compiled in, it also tracks the switch bank as a Johnson-sequence position encoder and flags out-of-order moves. It sits between the board switch pins and the seven-segment and display logic.

## Interface
- `N`, default 3: number of switches/channels; legal range 2..8.
- `DEB_CYCLES`, default 4: consecutive stable cycles required to accept a new switch level; must be ≥1.
- `W`, default 4: width of each numeric field; must satisfy 2^W > N+1.
- `clk`, input, 1: single system clock.
- `rst_n`, input, 1: reset, asynchronous assertion, active-low.
- `sw`, input, N: raw asynchronous switch levels; `sw[i]` is channel i+1.
- `nums`, output, N*W: packed fields; field i is `nums[i*W +: W]`.
- `code_valid`, output, 1: the current debounced pattern is a legal Johnson code.
- `chg`, output, 1: one-cycle pulse when `nums` updates.
- `pos`, output, $clog2(2N): Johnson position 0..2N-1.
- `dir`, output, 1: direction of the last accepted step; 1 means forward.
- `seq_err`, output, 1: the sequence checker is in FAULT.

## Operation
- **Synchroniser:** a 2-flop synchroniser on every `sw` bit.
- **Debounce:** one counter per channel.
  - The counter increments while the synced bit differs from the stable bit.
  - It clears on any cycle where the two are equal.
  - When it reaches DEB_CYCLES, the stable bit takes the synced value and the counter clears.
- **Legal codes:** the 2N Johnson states, with bit order `sw[N-1]` as MSB.
  - Position k ≤ N: the top k bits are 1.
  - Position k > N: the low 2N−k bits are 1.
  - For N=3 the legal codes are 000, 100, 110, 111, 011, 001. The codes 010 and 101 are illegal.
- **Decode:** registered, and evaluated only when the stable vector changes.
  - Legal code: field i = i+1 if stable bit i is 1, else 0. `code_valid` = 1.
  - Illegal code: every field = N+1. `code_valid` = 0.
- **Sequence FSM:** states TRACK and FAULT.
  - In TRACK, a new legal code at (pos+1) mod 2N sets `pos` and `dir` = 1.
  - In TRACK, a new legal code at (pos−1) mod 2N sets `pos` and `dir` = 0.
  - In TRACK, any other new code (a jump or an illegal code) goes to FAULT and sets `seq_err` = 1. `pos` holds.
  - In FAULT, a return to code 0 goes to TRACK with `pos` = 0 and `seq_err` = 0. All other codes keep FAULT.
- **Simultaneous flips:** channels debounce independently. A two-switch move that lands on different cycles is judged as two separate changes.

## Timing
- **Reset values:** stable vector and synchronisers 0, `nums` all 0, `code_valid` 1, `chg` 0, `pos` 0, `dir` 1, `seq_err` 0, FSM in TRACK.
- **Latency:** from a clean `sw` edge to updated `nums`/`pos` is DEB_CYCLES+3 cycles. That is 2 synchroniser cycles, plus DEB_CYCLES debounce cycles, plus 1 decode register cycle.
- **Pulse:** `chg` is high in the same cycle the new `nums` first appears.
- **Glitches:** a glitch shorter than DEB_CYCLES synced cycles produces no output change and no `chg`.
- **Wrap-around:** position 2N−1 to position 0 counts as a forward step, and 0 to 2N−1 counts as a backward step.
- **Reset mid-debounce:** in-flight counts are discarded. Outputs return to reset values immediately, without waiting for a clock.

## Configuration
- **Macro:** `SWITCH_SEQ_CHECK_EN`.
- **Defined:** the FSM, `pos`, `dir` and `seq_err` behave as described above.
- **Undefined:** the FSM and position logic are not built. `pos` = 0, `dir` = 1 and `seq_err` = 0 constantly. `nums`, `code_valid` and `chg` are unchanged.

## Structure
- **Shared package `switch_pkg`:** the FSM state typedef (TRACK and FAULT), the function that maps a Johnson code to its position or to invalid, and the error-value constant N+1.
- **Sub-module `sw_debounce`:** a single-channel synchroniser and debouncer with parameter DEB_CYCLES, instantiated N times via generate.

## Test plan
All scenarios use N=3, DEB_CYCLES=4, W=4; `nums` is written as {n3,n2,n1}.
1. **Reset:** assert `rst_n`=0 mid-clock → `nums`=0 and `seq_err`=0 without waiting for an edge. `pos`=0 after release.
2. **Legal decode:** `sw`=100 held → after 7 cycles `nums`={3,0,0}, `chg` pulses once, `pos`=1, `dir`=1.
3. **Illegal code:** `sw`=101 reached from 001 → `nums`={4,4,4}, `code_valid`=0, `seq_err`=1. Then `sw`=000 → `seq_err`=0, `pos`=0.
4. **Full cycle:** walk 000→100→110→111→011→001→000 → `pos` goes 1,2,3,4,5,0 with `seq_err` staying 0. Walking in reverse gives `dir`=0.
5. **Bounce rejection:** toggle `sw[0]` high for 3 cycles, then low → no `chg`, `nums` unchanged.
6. **Jump fault:** from 000 go straight to 111 → `seq_err`=1, `pos` stays 0, `nums`={3,2,1}.
